// File: rtl/usb_spi_pkg.sv
// SPI register-responder shared types: FSM states, special register indices, command fields.
// No logic, so no latency.
// No flow control; types only.
package usb_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_t;

  localparam logic [4:0] REG_HIRQ = 5'd25;
  localparam logic [4:0] REG_HIEN = 5'd26;

  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;
  localparam int CMD_DIR_BIT  = 1;

  function automatic logic [4:0] cmd_addr(input logic [7:0] cmd);
    return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
  endfunction

  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return cmd[CMD_DIR_BIT];
  endfunction

endpackage

// File: rtl/usb_spi_responder_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, with rise/fall pulses on the synchronized copy.
// Level valid 2 Clk after the pin changes; the edge pulse is seen in that same cycle and acted on at the next edge.
// No backpressure; pulses are one cycle wide.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  // All stages reset to 0 so a held-low pin after reset produces no fall pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/usb_spi_responder.sv
// Mode-0 SPI slave emulating a MAX3421E-style 32x8 register file with W1C HIRQ and active-low interrupt.
// MISO 3 Clk after SS/SCLK fall; write commit 3 Clk after the 8th SCLK rise; dbg_data 1 Clk.
// No backpressure: the master must respect SCLK_MIN_DIV; SS high aborts any partial byte.
module usb_spi_responder
  import usb_spi_pkg::*;
#(
  parameter int SCLK_MIN_DIV = 8
) (
  input  logic       Clk,
  input  logic       reset_rtl_0,
  input  logic       usb_spi_sclk,
  input  logic       usb_spi_ss,
  input  logic       usb_spi_mosi,
  output logic       usb_spi_miso,
  input  logic       gpio_usb_rst_tri_i,
  output logic       gpio_usb_int_tri_o,
  input  logic [7:0] irq_set,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [4:0] dbg_addr,
  output logic [7:0] dbg_data
);

  // Three cycles of edge latency must fit inside half an SCLK period.
  if (SCLK_MIN_DIV < 8) begin : g_div_check
    $error("SCLK_MIN_DIV must be at least 8");
  end

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  sync_edge u_sync_sclk (
    .clk_i  (Clk),
    .rst_i  (reset_rtl_0),
    .async_i(usb_spi_sclk),
    .lvl_o  (sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge u_sync_ss (
    .clk_i  (Clk),
    .rst_i  (reset_rtl_0),
    .async_i(usb_spi_ss),
    .lvl_o  (ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  sync_edge u_sync_mosi (
    .clk_i  (Clk),
    .rst_i  (reset_rtl_0),
    .async_i(usb_spi_mosi),
    .lvl_o  (mosi_lvl),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, ss_rise, mosi_rise, mosi_fall};

  logic soft_rst;
  assign soft_rst = reset_rtl_0 | ~gpio_usb_rst_tri_i;

  spi_state_t state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_q;
  logic [7:0] tx_q;
  logic [4:0] addr_q;
  logic       dir_wr_q;
  logic       miso_q;
  logic       wr_strobe_q;
  logic [4:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] dbg_q;
  logic       int_q;
  logic [7:0] regs_q [32];

  logic [7:0] rx_byte;
  logic       byte_done;
  logic       commit;
  logic [7:0] hirq_clr;
  logic [7:0] hirq_d;

  assign rx_byte   = {rx_q[6:0], mosi_lvl};
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7) & ~ss_lvl & ~ss_fall;
  assign commit    = byte_done & (state_q == DATA) & dir_wr_q;
  assign hirq_clr  = (commit && (addr_q == REG_HIRQ)) ? rx_byte : 8'h00;
  // A same-cycle irq_set outranks the write-1-to-clear.
  assign hirq_d    = (regs_q[REG_HIRQ] & ~hirq_clr) | irq_set;

  always_ff @(posedge Clk) begin
    wr_strobe_q <= 1'b0;
    if (soft_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      addr_q    <= 5'd0;
      dir_wr_q  <= 1'b0;
      miso_q    <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 8'h00;
    end else if (ss_fall) begin
      state_q   <= CMD;
      bit_cnt_q <= 3'd0;
      tx_q      <= {regs_q[REG_HIRQ][6:0], 1'b0};
      miso_q    <= regs_q[REG_HIRQ][7];
    end else if (ss_lvl) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      miso_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        CMD, DATA: begin
          if (sclk_rise) begin
            rx_q      <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == CMD) begin
                state_q  <= DATA;
                addr_q   <= cmd_addr(rx_byte);
                dir_wr_q <= cmd_is_write(rx_byte);
                tx_q     <= cmd_is_write(rx_byte) ? 8'h00 : regs_q[cmd_addr(rx_byte)];
              end else if (dir_wr_q) begin
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= addr_q;
                wr_data_q   <= rx_byte;
              end else begin
                tx_q <= regs_q[addr_q];
              end
            end
          end else if (sclk_fall) begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (soft_rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 8'h00;
      end
      int_q <= 1'b1;
      dbg_q <= 8'h00;
    end else begin
      if (commit && (addr_q != REG_HIRQ)) begin
        regs_q[addr_q] <= rx_byte;
      end
      regs_q[REG_HIRQ] <= hirq_d;
      int_q <= ~|(regs_q[REG_HIRQ] & regs_q[REG_HIEN]);
      dbg_q <= regs_q[dbg_addr];
    end
  end

  assign usb_spi_miso       = miso_q;
  assign gpio_usb_int_tri_o = int_q;
  assign wr_strobe          = wr_strobe_q;
  assign wr_addr            = wr_addr_q;
  assign wr_data            = wr_data_q;
  assign dbg_data           = dbg_q;

endmodule

// File: tb/tb_usb_spi_responder.sv
// Directed bench for usb_spi_responder: SPI master model with 16-Clk SCLK period and hand-computed expectations.
module tb_usb_spi_responder;

  logic       Clk = 1'b0;
  logic       reset_rtl_0 = 1'b1;
  logic       usb_spi_sclk = 1'b0;
  logic       usb_spi_ss = 1'b1;
  logic       usb_spi_mosi = 1'b0;
  logic       usb_spi_miso;
  logic       gpio_usb_rst_tri_i = 1'b1;
  logic       gpio_usb_int_tri_o;
  logic [7:0] irq_set = 8'h00;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] dbg_addr = 5'd0;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_strb = 0;
  logic [4:0] s_addr = 5'd0;
  logic [7:0] s_data = 8'h00;

  usb_spi_responder #(.SCLK_MIN_DIV(8)) dut (
    .Clk               (Clk),
    .reset_rtl_0       (reset_rtl_0),
    .usb_spi_sclk      (usb_spi_sclk),
    .usb_spi_ss        (usb_spi_ss),
    .usb_spi_mosi      (usb_spi_mosi),
    .usb_spi_miso      (usb_spi_miso),
    .gpio_usb_rst_tri_i(gpio_usb_rst_tri_i),
    .gpio_usb_int_tri_o(gpio_usb_int_tri_o),
    .irq_set           (irq_set),
    .wr_strobe         (wr_strobe),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .dbg_addr          (dbg_addr),
    .dbg_data          (dbg_data)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (wr_strobe === 1'b1) begin
      n_strb = n_strb + 1;
      s_addr = wr_addr;
      s_data = wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    usb_spi_mosi = b;
    clks(8);
    usb_spi_sclk = 1'b1;
    r = usb_spi_miso;
    clks(8);
    usb_spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(t[i], b);
      r[i] = b;
    end
  endtask

  task automatic xfer(input int n, input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                      output logic [7:0] r0, output logic [7:0] r1, output logic [7:0] r2);
    r2 = 8'h00;
    usb_spi_ss = 1'b0;
    clks(8);
    spi_byte(t0, r0);
    spi_byte(t1, r1);
    if (n > 2) spi_byte(t2, r2);
    clks(8);
    usb_spi_ss = 1'b1;
    clks(8);
  endtask

  task automatic rd_dbg(input logic [4:0] a, output logic [7:0] d);
    dbg_addr = a;
    clks(2);
    d = dbg_data;
  endtask

  initial begin
    logic [7:0] r0, r1, r2, d;
    logic b;
    int base;

    clks(5);
    chk("rst_miso", 32'(usb_spi_miso), 32'h0);
    chk("rst_int", 32'(gpio_usb_int_tri_o), 32'h1);
    chk("rst_strobe", 32'(wr_strobe), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_dbg", 32'(dbg_data), 32'h0);
    reset_rtl_0 = 1'b0;
    clks(5);

    // Write HIEN = 0x0F
    base = n_strb;
    xfer(2, 8'hD2, 8'h0F, 8'h00, r0, r1, r2);
    chk("wr_hien_status", 32'(r0), 32'h00);
    chk("wr_hien_strobes", 32'(n_strb - base), 32'd1);
    chk("wr_hien_addr", 32'(s_addr), 32'd26);
    chk("wr_hien_data", 32'(s_data), 32'h0F);
    rd_dbg(5'd26, d);
    chk("dbg_hien", 32'(d), 32'h0F);
    chk("int_idle_high", 32'(gpio_usb_int_tri_o), 32'h1);

    // Read HIEN, 2 and 3 bytes
    base = n_strb;
    xfer(2, 8'hD0, 8'h00, 8'h00, r0, r1, r2);
    chk("rd2_status", 32'(r0), 32'h00);
    chk("rd2_data", 32'(r1), 32'h0F);
    xfer(3, 8'hD0, 8'h00, 8'h00, r0, r1, r2);
    chk("rd3_data1", 32'(r1), 32'h0F);
    chk("rd3_data2", 32'(r2), 32'h0F);
    chk("rd_no_strobe", 32'(n_strb - base), 32'd0);

    // Interrupt set
    irq_set = 8'h01;
    clks(1);
    irq_set = 8'h00;
    clks(1);
    chk("int_low_after_set", 32'(gpio_usb_int_tri_o), 32'h0);
    rd_dbg(5'd25, d);
    chk("dbg_hirq_set", 32'(d), 32'h01);
    xfer(2, 8'hD0, 8'h00, 8'h00, r0, r1, r2);
    chk("status_shows_hirq", 32'(r0), 32'h01);

    // W1C clear
    base = n_strb;
    xfer(2, 8'hCA, 8'h01, 8'h00, r0, r1, r2);
    chk("w1c_strobe_addr", 32'(s_addr), 32'd25);
    chk("w1c_strobes", 32'(n_strb - base), 32'd1);
    rd_dbg(5'd25, d);
    chk("dbg_hirq_clr", 32'(d), 32'h00);
    chk("int_high_after_clr", 32'(gpio_usb_int_tri_o), 32'h1);

    // Set beats clear: pulse irq_set exactly on the commit cycle
    usb_spi_ss = 1'b0;
    clks(8);
    spi_byte(8'hCA, r0);
    for (int i = 0; i < 7; i++) spi_bit(1'b0, b);
    usb_spi_mosi = 1'b1;
    clks(8);
    usb_spi_sclk = 1'b1;
    clks(2);
    irq_set = 8'h01;
    clks(1);
    irq_set = 8'h00;
    chk("sbc_strobe_aligned", 32'(wr_strobe), 32'h1);
    clks(5);
    usb_spi_sclk = 1'b0;
    clks(8);
    usb_spi_ss = 1'b1;
    clks(8);
    rd_dbg(5'd25, d);
    chk("sbc_hirq", 32'(d), 32'h01);
    chk("sbc_int_low", 32'(gpio_usb_int_tri_o), 32'h0);

    // Aborted byte
    base = n_strb;
    usb_spi_ss = 1'b0;
    clks(8);
    spi_byte(8'hD2, r0);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    clks(8);
    usb_spi_ss = 1'b1;
    clks(6);
    chk("abort_no_strobe", 32'(n_strb - base), 32'd0);
    chk("abort_miso", 32'(usb_spi_miso), 32'h0);
    rd_dbg(5'd26, d);
    chk("abort_hien", 32'(d), 32'h0F);

    // Hard reset mid data byte
    base = n_strb;
    usb_spi_ss = 1'b0;
    clks(8);
    spi_byte(8'hD2, r0);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
    reset_rtl_0 = 1'b1;
    clks(2);
    chk("mid_rst_miso", 32'(usb_spi_miso), 32'h0);
    chk("mid_rst_int", 32'(gpio_usb_int_tri_o), 32'h1);
    chk("mid_rst_strobe", 32'(wr_strobe), 32'h0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'h0);
    chk("mid_rst_dbg", 32'(dbg_data), 32'h0);
    reset_rtl_0 = 1'b0;
    clks(2);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    spi_byte(8'h5A, r1);
    clks(8);
    usb_spi_ss = 1'b1;
    clks(8);
    chk("post_rst_ignored", 32'(n_strb - base), 32'd0);
    rd_dbg(5'd26, d);
    chk("post_rst_hien", 32'(d), 32'h00);

    base = n_strb;
    xfer(2, 8'h1A, 8'h5A, 8'h00, r0, r1, r2);
    chk("post_rst_strobes", 32'(n_strb - base), 32'd1);
    chk("post_rst_addr", 32'(s_addr), 32'd3);
    chk("post_rst_data", 32'(s_data), 32'h5A);
    xfer(2, 8'h18, 8'h00, 8'h00, r0, r1, r2);
    chk("post_rst_rd_status", 32'(r0), 32'h00);
    chk("post_rst_rd_data", 32'(r1), 32'h5A);

    // Soft reset via GPIO
    xfer(2, 8'hD2, 8'h33, 8'h00, r0, r1, r2);
    rd_dbg(5'd26, d);
    chk("pre_soft_hien", 32'(d), 32'h33);
    gpio_usb_rst_tri_i = 1'b0;
    clks(3);
    gpio_usb_rst_tri_i = 1'b1;
    clks(2);
    rd_dbg(5'd26, d);
    chk("soft_rst_hien", 32'(d), 32'h00);
    rd_dbg(5'd3, d);
    chk("soft_rst_reg3", 32'(d), 32'h00);
    xfer(2, 8'hD0, 8'h00, 8'h00, r0, r1, r2);
    chk("soft_rst_spi_hien", 32'(r1), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_spi_responder.md
# usb_spi_responder

Synthesizable SPI slave that emulates the MAX3421E-style register-access protocol seen by the MicroBlaze USB SPI master. It sits at the far end of the `usb_spi_*` and `gpio_usb_*` nets, on-chip in loopback builds, so driver bring-up and hardware-in-loop tests run without the USB shield. It holds a 32×8 register file, a write-1-to-clear interrupt register, an active-low interrupt output, and a fabric-side write-observation and debug-read port.

## Interface
- `SCLK_MIN_DIV`, default 8: minimum SCLK period in `Clk` cycles. The design is guaranteed correct only at or above this period.
- `Clk`  in  1  system clock, 100 MHz.
- `reset_rtl_0`  in  1  synchronous, active-high reset.
- `usb_spi_sclk`  in  1  SPI clock from master, asynchronous, mode 0.
- `usb_spi_ss`  in  1  active-low slave select, asynchronous.
- `usb_spi_mosi`  in  1  master-out data, asynchronous.
- `usb_spi_miso`  out  1  slave-out data; driven 0 when deselected.
- `gpio_usb_rst_tri_i`  in  1  active-low soft reset from master GPIO.
- `gpio_usb_int_tri_o`  out  1  active-low interrupt: `~|(HIRQ & HIEN)`.
- `irq_set`  in  8  per-bit set pulses into HIRQ (reg 25).
- `wr_strobe`  out  1  one-cycle pulse when a SPI write commits.
- `wr_addr`  out  5  register written.
- `wr_data`  out  8  byte written.
- `dbg_addr`  in  5  fabric debug-read address.
- `dbg_data`  out  8  `reg[dbg_addr]`, registered, 1-cycle latency.

## Operation
- **Input synchronization:** SCLK, SS and MOSI each pass through a 2-flop synchronizer. Rise and fall edges of SCLK and SS are detected on the synchronized copies.
- **Command byte:** bits [7:3] are the register address, bit 1 is the direction (1 = write), bits 2 and 0 are ignored.
- **Status during command:** while the command byte shifts in, MISO shifts out HIRQ (reg 25), MSB first.
- **Mode 0 timing:** MOSI is sampled on SCLK rise. MISO changes only on SCLK fall or on the SS fall, each byte MSB first.
- **FSM states:**
  - IDLE → CMD on SS fall. The TX shift register loads HIRQ.
  - CMD → DATA on the 8th rise. The address and direction are latched. For a read, TX loads `reg[addr]`.
  - DATA loops per byte. On each 8th rise:
    - write: commit the byte to `reg[addr]` and pulse `wr_strobe`;
    - read: reload TX from `reg[addr]`.
  - The address never increments; multi-byte transfers repeat the same register.
  - Any state → IDLE when SS goes high. A partial byte is discarded with no commit and no strobe, and MISO goes to 0.
- **Reg 25 (HIRQ):** a SPI write is write-1-to-clear. The update is `HIRQ = (HIRQ & ~wdata) | irq_set`, so `irq_set` wins over a same-cycle clear.
- **Reg 26 (HIEN):** plain read/write. All other registers are plain read/write.
- **Soft reset:** `gpio_usb_rst_tri_i` low clears the register file and forces IDLE, with the same effect as `reset_rtl_0`.
- **Reset values:** `usb_spi_miso`=0, `gpio_usb_int_tri_o`=1, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0, `dbg_data`=0, all registers 0, FSM IDLE, bit counter 0.

## Timing
- **Synchronizer latency:** 2 `Clk` cycles, plus 1 cycle for edge detect.
- **MISO after SS fall:** the status MSB is valid 3 `Clk` after SS falls. The master must allow ≥4 `Clk` from SS fall to the first SCLK rise.
- **MISO after SCLK fall:** MISO updates ≤3 `Clk` after the SCLK fall. This is inside half a period when `SCLK_MIN_DIV` ≥ 8.
- **Write strobe:** `wr_strobe` pulses 3 `Clk` after the 8th SCLK rise of a write data byte, and the register updates in the same cycle.
- **Interrupt:** `gpio_usb_int_tri_o` is registered, 1 `Clk` after any HIRQ or HIEN change.
- **Reset mid-transfer:** reset wins over everything. The FSM returns to IDLE and remains there until the next SS fall; a transfer in progress is ignored.

## Structure
- **Package `usb_spi_pkg`:**
  - `spi_state_t` enum (IDLE, CMD, DATA);
  - `localparam` `REG_HIRQ`=25, `REG_HIEN`=26;
  - command-byte field positions.
- **Sub-module `sync_edge`:** 2-flop synchronizer plus rise/fall pulse outputs, instantiated three times.

## Test plan
- **Write HIEN:** SS low, shift 0xD2 then 0x0F, SS high → `wr_strobe` once with addr 26 / data 0x0F; `dbg_addr`=26 gives 0x0F.
- **Read HIEN:** shift 0xD0 then 0x00 → MISO returns 0x00 (HIRQ) during the command byte, then 0x0F. A 3-byte read returns 0x0F twice.
- **Interrupt set and clear:** with HIEN=0x0F, pulse `irq_set`=0x01 → int goes low within 2 `Clk`. Write 0xCA then 0x01 → HIRQ=0x00 and int goes high.
- **Set beats clear:** `irq_set`=0x01 in the same cycle as a W1C commit of 0x01 → HIRQ stays 0x01.
- **Aborted byte:** write command 0xD2 plus 5 data bits, then SS high → no strobe, HIEN unchanged, MISO=0.
- **Resets:** `reset_rtl_0` mid-data-byte → all outputs at reset values, and the next full transaction works. `gpio_usb_rst_tri_i` low → HIEN reads 0x00.
